// File: rtl/dma_burst_splitter.sv
// Splits one DMA descriptor into AVMM burst commands of at most BURST_MAX words,
// never crossing a BOUNDARY_BYTES boundary on either address. Optional counters: DMA_BURST_SPLITTER_STATS_EN.
module dma_burst_splitter #(
    parameter int unsigned SRC_ADDR_WIDTH   = 48,
    parameter int unsigned DST_ADDR_WIDTH   = 48,
    parameter int unsigned XFER_SIZE_WIDTH  = 40,
    parameter int unsigned DATA_BYTES       = 64,
    parameter int unsigned BURST_MAX        = 4,
    parameter int unsigned BURSTCOUNT_WIDTH = 7,
    parameter int unsigned BOUNDARY_BYTES   = 4096
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sclr,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [SRC_ADDR_WIDTH-1:0]   cmd_src_addr,
    input  logic [DST_ADDR_WIDTH-1:0]   cmd_dst_addr,
    input  logic [XFER_SIZE_WIDTH-1:0]  cmd_length,
    output logic                        burst_valid,
    input  logic                        burst_ready,
    output logic [SRC_ADDR_WIDTH-1:0]   burst_src_addr,
    output logic [DST_ADDR_WIDTH-1:0]   burst_dst_addr,
    output logic [BURSTCOUNT_WIDTH-1:0] burst_count,
    output logic                        burst_last,
    output logic                        busy,
    output logic                        xfer_done,
    output logic [31:0]                 stat_burst_cnt,
    output logic [31:0]                 stat_word_cnt
);

    localparam int unsigned OFF_W  = $clog2(DATA_BYTES);
    localparam int unsigned BND_W  = $clog2(BOUNDARY_BYTES);
    localparam int unsigned WORD_W = XFER_SIZE_WIDTH - OFF_W;
    localparam int unsigned CMP_W  = 64;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

    state_t              state;
    logic [WORD_W-1:0]   remaining;
    logic [BND_W:0]      src_gap;
    logic [BND_W:0]      dst_gap;
    logic [CMP_W-1:0]    next_count;
    logic                len_zero;

    // Next burst size: smallest of the burst limit, words left and both boundary gaps.
    always_comb begin
        src_gap    = (BND_W+1)'(BOUNDARY_BYTES) - (BND_W+1)'(burst_src_addr[BND_W-1:0]);
        dst_gap    = (BND_W+1)'(BOUNDARY_BYTES) - (BND_W+1)'(burst_dst_addr[BND_W-1:0]);
        next_count = CMP_W'(BURST_MAX);
        if (CMP_W'(remaining) < next_count) begin
            next_count = CMP_W'(remaining);
        end
        if (CMP_W'(src_gap >> OFF_W) < next_count) begin
            next_count = CMP_W'(src_gap >> OFF_W);
        end
        if (CMP_W'(dst_gap >> OFF_W) < next_count) begin
            next_count = CMP_W'(dst_gap >> OFF_W);
        end
        len_zero = ((cmd_length >> OFF_W) == XFER_SIZE_WIDTH'(0));
    end

    always_ff @(posedge clk) begin
        if (!reset_n || sclr) begin
            state          <= IDLE;
            cmd_ready      <= 1'b0;
            burst_valid    <= 1'b0;
            burst_src_addr <= '0;
            burst_dst_addr <= '0;
            burst_count    <= '0;
            burst_last     <= 1'b0;
            busy           <= 1'b0;
            xfer_done      <= 1'b0;
            remaining      <= '0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        // Word-align both addresses; a trailing partial word is dropped.
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        burst_src_addr <= cmd_src_addr & ~SRC_ADDR_WIDTH'(DATA_BYTES - 1);
                        burst_dst_addr <= cmd_dst_addr & ~DST_ADDR_WIDTH'(DATA_BYTES - 1);
                        remaining      <= WORD_W'(cmd_length >> OFF_W);
                        if (len_zero) begin
                            state     <= DONE;
                            xfer_done <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    burst_count <= BURSTCOUNT_WIDTH'(next_count);
                    burst_last  <= (next_count == CMP_W'(remaining));
                    burst_valid <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    if (burst_ready) begin
                        burst_valid    <= 1'b0;
                        burst_src_addr <= burst_src_addr + (SRC_ADDR_WIDTH'(burst_count) << OFF_W);
                        burst_dst_addr <= burst_dst_addr + (DST_ADDR_WIDTH'(burst_count) << OFF_W);
                        remaining      <= remaining - WORD_W'(burst_count);
                        if (burst_last) begin
                            state     <= DONE;
                            xfer_done <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMA_BURST_SPLITTER_STATS_EN
    logic [32:0] word_sum;

    always_comb begin
        word_sum = {1'b0, stat_word_cnt} + 33'(burst_count);
    end

    // Saturating burst/word counters, advanced on each accepted burst.
    always_ff @(posedge clk) begin
        if (!reset_n || sclr) begin
            stat_burst_cnt <= '0;
            stat_word_cnt  <= '0;
        end else if (state == ISSUE && burst_ready) begin
            if (stat_burst_cnt != 32'hFFFF_FFFF) begin
                stat_burst_cnt <= stat_burst_cnt + 32'd1;
            end
            stat_word_cnt <= word_sum[32] ? 32'hFFFF_FFFF : word_sum[31:0];
        end
    end
`else
    assign stat_burst_cnt = '0;
    assign stat_word_cnt  = '0;
`endif

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Self-checking bench for dma_burst_splitter: directed table, hand sequences
// for backpressure and mid-transfer clear, and randomized descriptors against a reference model.
module tb_dma_burst_splitter;

    typedef struct packed {
        logic [47:0] src;
        logic [47:0] dst;
        logic [6:0]  cnt;
        logic        last;
    } burst_t;

    typedef struct packed {
        logic [47:0]      src;
        logic [47:0]      dst;
        logic [39:0]      len;
        logic [31:0]      nb;
        burst_t [2:0]     b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sclr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_src_addr;
    logic [47:0] cmd_dst_addr;
    logic [39:0] cmd_length;
    logic        burst_valid;
    logic        burst_ready;
    logic [47:0] burst_src_addr;
    logic [47:0] burst_dst_addr;
    logic [6:0]  burst_count;
    logic        burst_last;
    logic        busy;
    logic        xfer_done;
    logic [31:0] stat_burst_cnt;
    logic [31:0] stat_word_cnt;

    int          checks = 0;
    int          failures = 0;
    burst_t      exp_q[$];
    logic [63:0] exp_bursts = 0;
    logic [63:0] exp_words = 0;
    vec_t        vec[6];

    dma_burst_splitter dut (
        .clk(clk), .reset_n(reset_n), .sclr(sclr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_length(cmd_length),
        .burst_valid(burst_valid), .burst_ready(burst_ready),
        .burst_src_addr(burst_src_addr), .burst_dst_addr(burst_dst_addr),
        .burst_count(burst_count), .burst_last(burst_last),
        .busy(busy), .xfer_done(xfer_done),
        .stat_burst_cnt(stat_burst_cnt), .stat_word_cnt(stat_word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic burst_t mk(input logic [47:0] s, input logic [47:0] d,
                                  input logic [6:0] c, input logic l);
        burst_t b;
        b.src = s; b.dst = d; b.cnt = c; b.last = l;
        return b;
    endfunction

    function automatic logic [63:0] stat_exp(input logic [63:0] v);
`ifdef DMA_BURST_SPLITTER_STATS_EN
        return v;
`else
        return 64'(0) & v;
`endif
    endfunction

    // Reference: greedy split by burst limit, words left and 4 KiB distance on each address.
    task automatic model_fill(input logic [47:0] s, input logic [47:0] d, input logic [39:0] len);
        logic [47:0] ss, dd;
        logic [63:0] w, c, sg, dg;
        ss = s & ~48'h3F;
        dd = d & ~48'h3F;
        w  = 64'(len) / 64;
        exp_q.delete();
        while (w > 0) begin
            sg = (4096 - 64'(ss % 4096)) / 64;
            dg = (4096 - 64'(dd % 4096)) / 64;
            c = 4;
            if (w < c)  c = w;
            if (sg < c) c = sg;
            if (dg < c) c = dg;
            exp_q.push_back(mk(ss, dd, 7'(c), w == c));
            ss = ss + 48'(c * 64);
            dd = dd + 48'(c * 64);
            w  = w - c;
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_stat_bursts"}, 64'(stat_burst_cnt), stat_exp(exp_bursts));
        chk({tag, "_stat_words"},  64'(stat_word_cnt),  stat_exp(exp_words));
    endtask

    // Issue one descriptor and walk the expected bursts in exp_q; bp<0 picks random stalls.
    task automatic run_desc(input logic [47:0] s, input logic [47:0] d, input logic [39:0] len, input int bp);
        int t, k;
        burst_t e;
        t = 0;
        while (!cmd_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        chk("busy_idle", 64'(busy), 64'(0));
        cmd_valid = 1'b1; cmd_src_addr = s; cmd_dst_addr = d; cmd_length = len;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_ready_after_accept", 64'(cmd_ready), 64'(0));
        if (exp_q.size() == 0) begin
            chk("zero_done", 64'(xfer_done), 64'(1));
            chk("zero_no_valid", 64'(burst_valid), 64'(0));
            @(negedge clk);
            chk("zero_done_pulse", 64'(xfer_done), 64'(0));
            chk("zero_ready_back", 64'(cmd_ready), 64'(1));
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            chk("calc_no_valid", 64'(burst_valid), 64'(0));
            chk("calc_busy", 64'(busy), 64'(1));
            @(negedge clk);
            k = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
            for (int j = 0; j <= k; j++) begin
                chk("burst_valid", 64'(burst_valid), 64'(1));
                chk("burst_src", 64'(burst_src_addr), 64'(e.src));
                chk("burst_dst", 64'(burst_dst_addr), 64'(e.dst));
                chk("burst_count", 64'(burst_count), 64'(e.cnt));
                chk("burst_last", 64'(burst_last), 64'(e.last));
                burst_ready = (j == k);
                @(negedge clk);
            end
            burst_ready = 1'b0;
            exp_bursts++;
            exp_words += 64'(e.cnt);
            chk("no_valid_after_accept", 64'(burst_valid), 64'(0));
            if (e.last) begin
                chk("xfer_done", 64'(xfer_done), 64'(1));
                @(negedge clk);
                chk("xfer_done_pulse", 64'(xfer_done), 64'(0));
                chk("ready_after_done", 64'(cmd_ready), 64'(1));
            end else begin
                chk("no_early_done", 64'(xfer_done), 64'(0));
            end
        end
    endtask

    // Start a 16-word transfer and clear it while the second burst is pending.
    task automatic clear_test(input bit use_rst);
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1; cmd_src_addr = 48'h0; cmd_dst_addr = 48'h0; cmd_length = 40'd1024;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("clr_first_valid", 64'(burst_valid), 64'(1));
        burst_ready = 1'b1;
        @(negedge clk);
        burst_ready = 1'b0;
        @(negedge clk);
        chk("clr_second_valid", 64'(burst_valid), 64'(1));
        chk("clr_second_src", 64'(burst_src_addr), 64'h100);
        if (use_rst) reset_n = 1'b0; else sclr = 1'b1;
        @(negedge clk);
        reset_n = 1'b1; sclr = 1'b0;
        exp_bursts = 0; exp_words = 0;
        chk("clr_valid_low", 64'(burst_valid), 64'(0));
        chk("clr_busy_low", 64'(busy), 64'(0));
        chk("clr_ready_low", 64'(cmd_ready), 64'(0));
        chk("clr_no_done", 64'(xfer_done), 64'(0));
        chk("clr_count_zero", 64'(burst_count), 64'(0));
        check_stats("clr");
        @(negedge clk);
        chk("clr_ready_back", 64'(cmd_ready), 64'(1));
        chk("clr_no_done_late", 64'(xfer_done), 64'(0));
        chk("clr_still_idle", 64'(burst_valid), 64'(0));
    endtask

    initial begin
        logic [47:0] rs, rd;
        logic [39:0] rl;

        vec[0] = '{src: 48'h0, dst: 48'h2000, len: 40'd512, nb: 32'd2, b: '0};
        vec[0].b[0] = mk(48'h0,   48'h2000, 7'd4, 1'b0);
        vec[0].b[1] = mk(48'h100, 48'h2100, 7'd4, 1'b1);
        vec[1] = '{src: 48'hF80, dst: 48'h0, len: 40'd512, nb: 32'd3, b: '0};
        vec[1].b[0] = mk(48'hF80,  48'h0,   7'd2, 1'b0);
        vec[1].b[1] = mk(48'h1000, 48'h80,  7'd4, 1'b0);
        vec[1].b[2] = mk(48'h1100, 48'h180, 7'd2, 1'b1);
        vec[2] = '{src: 48'h40, dst: 48'h80, len: 40'd0, nb: 32'd0, b: '0};
        vec[3] = '{src: 48'h40, dst: 48'h80, len: 40'd63, nb: 32'd0, b: '0};
        vec[4] = '{src: 48'h3F, dst: 48'h1FC1, len: 40'd200, nb: 32'd2, b: '0};
        vec[4].b[0] = mk(48'h0,  48'h1FC0, 7'd1, 1'b0);
        vec[4].b[1] = mk(48'h40, 48'h2000, 7'd2, 1'b1);
        vec[5] = '{src: 48'hFFFF_FFFF_FFC0, dst: 48'h100, len: 40'd128, nb: 32'd2, b: '0};
        vec[5].b[0] = mk(48'hFFFF_FFFF_FFC0, 48'h100, 7'd1, 1'b0);
        vec[5].b[1] = mk(48'h0,              48'h140, 7'd1, 1'b1);

        reset_n = 1'b0; sclr = 1'b0; cmd_valid = 1'b0; burst_ready = 1'b0;
        cmd_src_addr = '0; cmd_dst_addr = '0; cmd_length = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_burst_valid", 64'(burst_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_xfer_done", 64'(xfer_done), 64'(0));
        chk("rst_src", 64'(burst_src_addr), 64'(0));
        check_stats("rst");
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 64'(cmd_ready), 64'(1));

        for (int i = 0; i < 6; i++) begin
            exp_q.delete();
            for (int j = 0; j < int'(vec[i].nb); j++) exp_q.push_back(vec[i].b[j]);
            run_desc(vec[i].src, vec[i].dst, vec[i].len, 0);
            check_stats("table");
        end

        exp_q.delete();
        exp_q.push_back(mk(48'h4000, 48'h8000, 7'd4, 1'b1));
        run_desc(48'h4000, 48'h8000, 40'd256, 5);

        clear_test(1'b0);
        clear_test(1'b1);

        // Clear wins over a descriptor offered in the same cycle.
        cmd_valid = 1'b1; sclr = 1'b1; cmd_src_addr = 48'h0; cmd_length = 40'd256;
        @(negedge clk);
        cmd_valid = 1'b0; sclr = 1'b0;
        chk("prio_busy", 64'(busy), 64'(0));
        chk("prio_ready_low", 64'(cmd_ready), 64'(0));
        repeat (2) @(negedge clk);
        chk("prio_no_burst", 64'(burst_valid), 64'(0));
        chk("prio_no_done", 64'(xfer_done), 64'(0));

        for (int n = 0; n < 40; n++) begin
            rs = {16'($urandom), $urandom};
            rd = {16'($urandom), $urandom};
            if ($urandom_range(0, 1) == 1) rs[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) rd[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            rl = 40'($urandom_range(0, 1600));
            model_fill(rs, rd, rl);
            run_desc(rs, rd, rl, -1);
            check_stats("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
